// File: rtl/mag_serial.sv
// mag_serial: nibble-serial unsigned magnitude comparator with cascade inputs.
// Operands are captured on an accepted start. One 4-bit slice is compared per
// clock, and the result is published with a one-cycle done pulse.
// Optional build macro MAG_SERIAL_EARLY_EN processes nibbles MS-first. With it,
// the compare finishes on the first unequal nibble. Without it, nibbles go
// LS-first and the latency is a fixed NIB clocks. Results are the same either way.

module mag_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             casc_gt,
    input  logic             casc_eq,
    input  logic             casc_lt,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    // state  | meaning
    // S_IDLE | waiting for start; outputs hold the last result
    // S_RUN  | comparing one nibble per clock; start is ignored

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        W_EQ = 2'd0,
        W_GT = 2'd1,
        W_LT = 2'd2
    } work_t;

    state_t           state;
    work_t            work;
    work_t            work_next;
    work_t            casc_work;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic             nib_gt;
    logic             nib_lt;
    logic             last_nib;
    logic             finish;

    // Resolve the cascade inputs: gt wins over lt; anything else is a tie.
    always_comb begin
        casc_work = W_EQ;
        casez ({casc_gt, casc_lt, casc_eq})
            3'b1??:  casc_work = W_GT;
            3'b01?:  casc_work = W_LT;
            default: casc_work = W_EQ;
        endcase
    end

`ifdef MAG_SERIAL_EARLY_EN
    // MS-first order: step 0 looks at the top nibble.
    always_comb begin
        idx = CW'(NIB - 1) - cnt;
    end
`else
    // LS-first order: step k looks at nibble k.
    always_comb begin
        idx = cnt;
    end
`endif

    // Select the current nibble of each captured operand.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (idx == CW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    // One 4-bit cascade slice: an unequal nibble overrides, equal passes through.
    always_comb begin
        nib_gt    = (nib_a > nib_b);
        nib_lt    = (nib_a < nib_b);
        last_nib  = (cnt == CW'(NIB - 1));
        work_next = work;
        if (nib_gt) begin
            work_next = W_GT;
        end else if (nib_lt) begin
            work_next = W_LT;
        end
`ifdef MAG_SERIAL_EARLY_EN
        // MS-first: the first difference decides, so stop there.
        finish = last_nib | nib_gt | nib_lt;
`else
        finish = last_nib;
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state <= S_IDLE;
            work  <= W_EQ;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        work  <= casc_work;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    work <= work_next;
                    if (finish) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        gt    <= (work_next == W_GT);
                        eq    <= (work_next == W_EQ);
                        lt    <= (work_next == W_LT);
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mag_serial.sv
// tb_mag_serial: table-driven vectors, hand sequences and random pairs for
// mag_serial. Expected results and latencies are queued at start acceptance
// and checked when done pulses.

module tb_mag_serial;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         resetl = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         casc_gt = 1'b0;
    logic         casc_eq = 1'b0;
    logic         casc_lt = 1'b0;
    logic         busy, done, gt, eq, lt;

    mag_serial #(.WIDTH(W)) dut (
        .clk     (clk),
        .resetl  (resetl),
        .start   (start),
        .a       (a),
        .b       (b),
        .casc_gt (casc_gt),
        .casc_eq (casc_eq),
        .casc_lt (casc_lt),
        .busy    (busy),
        .done    (done),
        .gt      (gt),
        .eq      (eq),
        .lt      (lt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] res;
        int         cyc;
        int         lat;
    } sb_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cg;
        logic         ce;
        logic         cl;
        logic [2:0]   res;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[8];
    int   n_pass = 0;
    int   n_total = 0;
    logic [2:0] prev = 3'b000;
    bit   prev_valid = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: unsigned compare, cascade (gt over lt, else eq) on a tie. {gt,eq,lt}
    function automatic logic [2:0] ref_res(input logic [W-1:0] va, input logic [W-1:0] vb,
                                           input logic cg, input logic cl);
        if (va > vb) return 3'b100;
        if (va < vb) return 3'b001;
        if (cg) return 3'b100;
        if (cl) return 3'b001;
        return 3'b010;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] va, input logic [W-1:0] vb);
`ifdef MAG_SERIAL_EARLY_EN
        for (int i = NIB - 1; i >= 0; i--)
            if (va[4*i +: 4] != vb[4*i +: 4]) return NIB - i;
`endif
        return NIB;
    endfunction

    // Scoreboard monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (!resetl) begin
            prev_valid = 0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", {29'd0, gt, eq, lt}, {29'd0, e.res});
                    chk("latency", cyc - e.cyc, e.lat);
                end
            end else if (prev_valid) begin
                chk("hold", {29'd0, gt, eq, lt}, {29'd0, prev});
            end
            prev = {gt, eq, lt};
            prev_valid = 1;
        end
    end

    task automatic push_exp(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [2:0] er);
        sb_t e;
        e.res = er;
        e.cyc = cyc;
        e.lat = ref_lat(va, vb);
        sb.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        int g = 0;
        while (done !== 1'b1 && g < 3 * NIB) begin
            @(posedge clk); #1;
            g++;
        end
        if (done !== 1'b1) chk(nm, 32'd0, 32'd1);
    endtask

    task automatic run_one(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic cg, input logic ce, input logic cl, input logic [2:0] er);
        int g = 0;
        while (busy === 1'b1 && g < 3 * NIB) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy === 1'b1) chk("busy_timeout", 32'd1, 32'd0);
        a = va; b = vb; casc_gt = cg; casc_eq = ce; casc_lt = cl;
        start = 1'b1;
        @(posedge clk); #1;
        push_exp(va, vb, er);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        {casc_gt, casc_eq, casc_lt} = 3'($urandom);
        wait_done("done_timeout");
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [2:0]   rc;
        int           mode, pos;

        tbl[0] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 3'b010};
        tbl[1] = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 3'b100};
        tbl[2] = '{16'h1235, 16'h1234, 1'b0, 1'b0, 1'b1, 3'b100};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 3'b100};
        tbl[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b010};
        tbl[5] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 1'b1, 3'b100};
        tbl[6] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1, 3'b001};
        tbl[7] = '{16'h0001, 16'h0100, 1'b1, 1'b0, 1'b0, 3'b001};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        @(negedge clk);
        resetl = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_one(tbl[i].a, tbl[i].b, tbl[i].cg, tbl[i].ce, tbl[i].cl, tbl[i].res);

        // Second start two clocks into a compare is ignored.
        a = 16'h1234; b = 16'h1234; {casc_gt, casc_eq, casc_lt} = 3'b010;
        start = 1'b1;
        @(posedge clk); #1;
        push_exp(16'h1234, 16'h1234, 3'b010);
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0000; {casc_gt, casc_eq, casc_lt} = 3'b001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignore_done_timeout");
        repeat (NIB + 2) @(posedge clk);
        #1;
        chk("ignore_no_pending", sb.size(), 32'd0);

        // Start held high through done: the next compare is accepted at once.
        a = 16'h1234; b = 16'h1234; {casc_gt, casc_eq, casc_lt} = 3'b010;
        start = 1'b1;
        @(posedge clk); #1;
        push_exp(16'h1234, 16'h1234, 3'b010);
        wait_done("held_done1_timeout");
        a = 16'h8000; b = 16'h7FFF; {casc_gt, casc_eq, casc_lt} = 3'b001;
        @(posedge clk); #1;
        push_exp(16'h8000, 16'h7FFF, 3'b100);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done("held_done2_timeout");

        // Reset in the middle of a compare aborts it with no done.
        @(posedge clk); #1;
        a = 16'h4321; b = 16'h4321; {casc_gt, casc_eq, casc_lt} = 3'b001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        resetl = 1'b0;
        #1;
        chk("reset_abort", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        @(posedge clk); #3;
        resetl = 1'b1;
        repeat (NIB + 3) @(posedge clk);
        #1;
        chk("post_reset_idle", {27'd0, busy, done, gt, eq, lt}, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                rb = ra;
            end else if (mode == 1) begin
                rb = ra;
                pos = $urandom_range(0, NIB - 1);
                rb[4*pos +: 4] = rb[4*pos +: 4] ^ 4'($urandom_range(1, 15));
            end else begin
                rb = W'($urandom);
            end
            rc = 3'($urandom);
            run_one(ra, rb, rc[2], rc[1], rc[0], ref_res(ra, rb, rc[2], rc[0]));
        end

        repeat (2) @(posedge clk);
        #2;
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
